// File: rtl/eth_tx_sched.sv
// rtl/eth_tx_sched.sv - round-robin scheduler sharing one eth_tx_fsm among NUM_REQ requesters
// Optional statistics counters enabled by defining ETH_TX_SCHED_STATS_EN.
module eth_tx_sched #(
    parameter int NUM_REQ      = 4,
    parameter int START_HOLD   = 4,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic                   i_eth_clk,
    input  logic                   i_rst,
    input  logic [NUM_REQ-1:0]     i_req,
    input  logic [16*NUM_REQ-1:0]  i_req_size,
    input  logic [NUM_REQ-1:0]     i_req_lfsr,
    input  logic [7:0]             i_gap_count,
    input  logic                   i_tx_busy,
    output logic                   o_eth_tx_start,
    output logic [15:0]            o_eth_tx_size,
    output logic                   o_eth_tx_lfsr_enable,
    output logic [7:0]             o_gap_count,
    output logic [2:0]             o_mem_sel,
    output logic [NUM_REQ-1:0]     o_grant,
    output logic [NUM_REQ-1:0]     o_done,
    output logic                   o_err
`ifdef ETH_TX_SCHED_STATS_EN
    ,
    output logic [31:0]            o_frame_count,
    output logic [31:0]            o_byte_count,
    output logic [15:0]            o_err_count
`endif
);

    typedef enum logic [2:0] {IDLE, START_HI, WAIT_BUSY, WAIT_DONE, DONE} state_t;

    state_t               state, state_n;
    logic [15:0]          cnt, cnt_n;
    logic [2:0]           ptr, ptr_n;
    logic                 start_n, lfsr_n, err_n;
    logic [15:0]          size_n;
    logic [7:0]           gap_n;
    logic [2:0]           sel_n;
    logic [NUM_REQ-1:0]   grant_n, done_n;
    logic                 found;
    int                   win;

    always_ff @(posedge i_eth_clk or posedge i_rst) begin
        if (i_rst) begin
            state                <= IDLE;
            cnt                  <= '0;
            ptr                  <= 3'(NUM_REQ - 1);
            o_eth_tx_start       <= 1'b0;
            o_eth_tx_size        <= '0;
            o_eth_tx_lfsr_enable <= 1'b0;
            o_gap_count          <= '0;
            o_mem_sel            <= '0;
            o_grant              <= '0;
            o_done               <= '0;
            o_err                <= 1'b0;
        end else begin
            state                <= state_n;
            cnt                  <= cnt_n;
            ptr                  <= ptr_n;
            o_eth_tx_start       <= start_n;
            o_eth_tx_size        <= size_n;
            o_eth_tx_lfsr_enable <= lfsr_n;
            o_gap_count          <= gap_n;
            o_mem_sel            <= sel_n;
            o_grant              <= grant_n;
            o_done               <= done_n;
            o_err                <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ptr_n   = ptr;
        start_n = o_eth_tx_start;
        size_n  = o_eth_tx_size;
        lfsr_n  = o_eth_tx_lfsr_enable;
        gap_n   = o_gap_count;
        sel_n   = o_mem_sel;
        grant_n = o_grant;
        done_n  = '0;
        err_n   = 1'b0;
        found   = 1'b0;
        win     = 0;
        // Search starts just past the last winner so every requester gets its turn.
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!found && i_req[(int'(ptr) + i) % NUM_REQ]) begin
                found = 1'b1;
                win   = (int'(ptr) + i) % NUM_REQ;
            end
        end
        case (state)
            IDLE: begin
                if (found && !i_tx_busy) begin
                    grant_n = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
                    sel_n   = 3'(win);
                    ptr_n   = 3'(win);
                    size_n  = i_req_size[16*win +: 16];
                    lfsr_n  = i_req_lfsr[win];
                    gap_n   = i_gap_count;
                    start_n = 1'b1;
                    cnt_n   = 16'd1;
                    state_n = START_HI;
                end
            end
            START_HI: begin
                // cnt holds the number of cycles elapsed since start rose, this one included.
                cnt_n = cnt + 16'd1;
                if (cnt == 16'(START_HOLD)) begin
                    start_n = 1'b0;
                    state_n = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                cnt_n = cnt + 16'd1;
                if (i_tx_busy) begin
                    state_n = WAIT_DONE;
                end else if (cnt == 16'(BUSY_TIMEOUT)) begin
                    done_n  = o_grant;
                    err_n   = 1'b1;
                    state_n = DONE;
                end
            end
            WAIT_DONE: begin
                if (!i_tx_busy) begin
                    done_n  = o_grant;
                    state_n = DONE;
                end
            end
            DONE: begin
                grant_n = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef ETH_TX_SCHED_STATS_EN
    always_ff @(posedge i_eth_clk or posedge i_rst) begin
        if (i_rst) begin
            o_frame_count <= '0;
            o_byte_count  <= '0;
            o_err_count   <= '0;
        end else if (state == DONE) begin
            if (o_err) begin
                if (o_err_count != 16'hFFFF)
                    o_err_count <= o_err_count + 16'd1;
            end else begin
                o_frame_count <= o_frame_count + 32'd1;
                // The engine pads short frames to 60 bytes, so count what goes on the wire.
                o_byte_count  <= o_byte_count +
                                 ((o_eth_tx_size < 16'd60) ? 32'd60 : {16'd0, o_eth_tx_size});
            end
        end
    end
`endif

endmodule
